// File: rtl/simplez_pkg.sv
// -----------------------------------------------------------------------------
// simplez_pkg
// Shared definitions for the Simplez F system: serial-loader byte codes, RAM
// geometry (address/data widths and the start of the peripheral window, which
// the core's peripheral decode also uses) and the loader state encoding.
// -----------------------------------------------------------------------------
package simplez_pkg;

    localparam int AW = 9;   // RAM word address width
    localparam int DW = 12;  // RAM word width

    localparam logic [7:0] LOAD_CMD = 8'h4C;  // 'L' opens a load frame
    localparam logic [7:0] ACK_OK   = 8'h4B;  // 'K' verified load
    localparam logic [7:0] ACK_ERR  = 8'h45;  // 'E' rejected or failed load

    // First address of the memory-mapped peripheral window; RAM ends below it.
    localparam logic [AW-1:0] RAM_DATA_TOP = 9'h1F8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DATA_H,
        S_DATA_L,
        S_WRITE,
        S_CHK,
        S_RESP,
        S_DONE
    } loader_state_e;

    // States in which the loader is waiting on the host for the next byte,
    // and therefore where inter-byte silence counts towards the timeout.
    function automatic logic waits_for_host(input loader_state_e s);
        return s inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
// Inter-byte watchdog for the serial loader. A down-counter that reloads to
// TIMEOUT-1 whenever clr is high, counts down while en is high, and raises
// expire for one cycle when it has spent TIMEOUT enabled, uncleared cycles.
//
// Ports:
//   clk     in   system clock
//   rstn    in   asynchronous active-low reset
//   en      in   count enable (loader is waiting for a host byte)
//   clr     in   reload the counter (byte received, or counting disabled)
//   expire  out  one-cycle pulse on the TIMEOUT-th idle cycle
// -----------------------------------------------------------------------------
module loader_timeout #(
    parameter int TIMEOUT = 12000000  // must be >= 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int            TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        expire = en && !clr && (cnt_q == '0);
        cnt_d  = cnt_q;
        if (clr || expire) begin
            cnt_d = LOAD;  // reload after expiry so the pulse is one cycle wide
        end else if (en) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simplez_loader.sv
// -----------------------------------------------------------------------------
// simplez_loader
// Serial bootloader for Simplez F. Receives 'L' N_H N_L {D_H D_L}*N CK from
// uart_rx, writes each 12-bit word into program RAM through the loader write
// path, answers 'K' or 'E' through uart_tx, and holds the core in reset from
// the accepted 'L' until a load has been verified.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_rcv, rx_data      byte strobe and byte from uart_rx
//   tx_ready             uart_tx idle
//   tx_start, tx_data    one-cycle send request and response byte to uart_tx
//   ram_cs, ram_rw       write strobe pair (cs=1, rw=0 only in WRITE)
//   ram_addr, ram_din    RAM word address and write data
//   cpu_rstn             active-low reset to the Simplez core
//   busy                 frame in progress
//   err                  last frame failed; cleared by the next accepted 'L'
// -----------------------------------------------------------------------------
module simplez_loader
    import simplez_pkg::*;
#(
    parameter int BAUD      = 104,       // uart divisor (B115200); used by the uart instances only
    parameter int RAM_WORDS = 504,
    parameter int TIMEOUT   = 12000000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_rcv,
    input  logic [7:0]    rx_data,
    input  logic          tx_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          err
);

    // BAUD only shapes the uart instances beside this block; nothing to build.
    if (BAUD <= 0) begin : g_baud_unused
    end

    // Never let a frame reach the peripheral window, whatever RAM_WORDS says.
    localparam int MAX_WORDS = (RAM_WORDS < int'(RAM_DATA_TOP)) ? RAM_WORDS : int'(RAM_DATA_TOP);
    typedef logic [AW:0] len_ext_t;
    localparam len_ext_t MAX_N = len_ext_t'(MAX_WORDS);

    loader_state_e state_q, state_d;
    logic [AW-1:0] n_q, n_d;            // frame length in words
    logic [AW-1:0] cnt_q, cnt_d;        // next word address
    logic [7:0]    sum_q, sum_d;        // running checksum of data bytes
    logic [3:0]    nib_q, nib_d;        // high nibble from D_H
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ram_cs_q, ram_cs_d;
    logic          ram_rw_q, ram_rw_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          cpu_rstn_q, cpu_rstn_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          to_en, to_expire;
    logic [AW-1:0] n_new;

    assign to_en = waits_for_host(state_q);
    assign n_new = {n_q[AW-1], rx_data};

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .en     (to_en),
        .clr    (rx_rcv || !to_en),
        .expire (to_expire)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        nib_d      = nib_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        ram_cs_d   = 1'b0;
        ram_rw_d   = 1'b1;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        cpu_rstn_d = cpu_rstn_q;
        busy_d     = busy_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: if (rx_rcv && rx_data == LOAD_CMD) begin
                state_d    = S_LEN_H;
                busy_d     = 1'b1;
                err_d      = 1'b0;
                cpu_rstn_d = 1'b0;
                cnt_d      = '0;
                sum_d      = '0;
            end
            S_LEN_H: if (rx_rcv) begin
                n_d     = {rx_data[0], 8'h00};
                state_d = S_LEN_L;
            end
            S_LEN_L: if (rx_rcv) begin
                n_d = n_new;
                if ({1'b0, n_new} > MAX_N) begin
                    state_d   = S_RESP;
                    tx_data_d = ACK_ERR;
                    err_d     = 1'b1;
                end else if (n_new == '0) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_DATA_H;
                end
            end
            S_DATA_H: if (rx_rcv) begin
                nib_d   = rx_data[3:0];
                sum_d   = sum_q + rx_data;
                state_d = S_DATA_L;
            end
            S_DATA_L: if (rx_rcv) begin
                // Outputs are registered: set them up now so they are valid
                // for exactly the one cycle spent in WRITE.
                sum_d      = sum_q + rx_data;
                ram_cs_d   = 1'b1;
                ram_rw_d   = 1'b0;
                ram_addr_d = cnt_q;
                ram_din_d  = {nib_q, rx_data};
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = cnt_q + AW'(1);
                state_d = (cnt_d == n_q) ? S_CHK : S_DATA_H;
            end
            S_CHK: if (rx_rcv) begin
                state_d = S_RESP;
                if (rx_data == sum_q) begin
                    tx_data_d = ACK_OK;
                end else begin
                    tx_data_d = ACK_ERR;
                    err_d     = 1'b1;
                end
            end
            S_RESP: if (tx_ready) begin
                tx_start_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                // While our own start pulse is still out, uart_tx has not yet
                // had a chance to drop tx_ready; ignore it for that cycle.
                if (!tx_start_q && tx_ready) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (tx_data_q == ACK_OK) cpu_rstn_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Expiry only fires in host-wait states with no byte this cycle, so it
        // never collides with a transition taken above.
        if (to_expire) begin
            state_d   = S_RESP;
            tx_data_d = ACK_ERR;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            nib_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ram_cs_q   <= 1'b0;
            ram_rw_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            cpu_rstn_q <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            nib_q      <= nib_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ram_cs_q   <= ram_cs_d;
            ram_rw_q   <= ram_rw_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign ram_cs   = ram_cs_q;
    assign ram_rw   = ram_rw_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign cpu_rstn = cpu_rstn_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_simplez_loader.sv
// -----------------------------------------------------------------------------
// tb_simplez_loader
// Bench for simplez_loader. A frame-level model parses each byte sequence
// sent to the loader and predicts the RAM writes, the response byte and the
// resulting err/cpu_rstn. A negedge monitor checks every RAM write and every
// response against those predictions; a stand-in uart_tx drops tx_ready for a
// few cycles after each start pulse.
// -----------------------------------------------------------------------------
module tb_simplez_loader;

    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_rcv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        ram_cs;
    logic        ram_rw;
    logic [8:0]  ram_addr;
    logic [11:0] ram_din;
    logic        cpu_rstn;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    simplez_loader #(
        .BAUD      (104),
        .RAM_WORDS (504),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_rcv   (rx_rcv),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .ram_cs   (ram_cs),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .err      (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Stand-in uart_tx: busy for 12 cycles after each start pulse.
    int uart_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn)               uart_cnt <= 0;
        else if (tx_start)       uart_cnt <= 12;
        else if (uart_cnt != 0)  uart_cnt <= uart_cnt - 1;
    end
    assign tx_ready = (uart_cnt == 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic [8:0]  addr;
        logic [11:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_resp[$];
    logic       m_err = 1'b0;
    logic       m_cpu = 1'b1;

    task automatic model_frame(input logic [7:0] fr[$]);
        int         i = 0;
        int         n;
        int         w = 0;
        logic [7:0] sum = 8'h00;
        logic [7:0] resp = 8'h45;
        while (i < fr.size() && fr[i] != 8'h4C) i++;
        if (i >= fr.size()) return;  // no 'L': all noise, no response
        i++;
        if (i + 2 <= fr.size()) begin
            n = {23'd0, fr[i][0], fr[i+1]};
            i += 2;
            if (n <= 504) begin
                while (w < n && i + 2 <= fr.size()) begin
                    exp_wr.push_back('{addr: 9'(w), data: {fr[i][3:0], fr[i+1]}});
                    sum = sum + fr[i] + fr[i+1];
                    i += 2;
                    w++;
                end
                if (w == n && i < fr.size() && fr[i] == sum) resp = 8'h4B;
            end
        end
        exp_resp.push_back(resp);
        m_err = (resp == 8'h45);
        m_cpu = (resp == 8'h4B);
    endtask

    // ---------------- monitor / compare process ----------------
    logic [11:0] mem [0:511];
    logic [7:0]  tx_log[$];
    int          n_writes = 0;
    int          last_rx_cyc = 0;
    int          tx_cyc = 0;

    always @(negedge clk) begin
        if (rstn) begin
            check("rw_is_not_cs", {31'd0, ram_rw}, {31'd0, !ram_cs});
            if (rx_rcv) last_rx_cyc = cyc;
            if (ram_cs) begin
                wr_t e;
                n_writes++;
                mem[ram_addr] = ram_din;
                check("core_held_during_write", {31'd0, cpu_rstn}, 32'd0);
                check("write_expected", {31'd0, exp_wr.size() != 0}, 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("write_addr", {23'd0, ram_addr}, {23'd0, e.addr});
                    check("write_data", {20'd0, ram_din}, {20'd0, e.data});
                end
            end
            if (tx_start) begin
                tx_cyc = cyc;
                tx_log.push_back(tx_data);
                check("busy_at_resp", {31'd0, busy}, 32'd1);
                check("resp_expected", {31'd0, exp_resp.size() != 0}, 32'd1);
                if (exp_resp.size() != 0) check("resp_byte", {24'd0, tx_data}, {24'd0, exp_resp.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_rcv  = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_rcv  = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (!busy && tx_ready) break;
        end
        check({tag, "_completes"}, {31'd0, k < budget}, 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fr[$]);
        model_frame(fr);
        foreach (fr[i]) send_byte(fr[i]);
        wait_idle(tag, 1000);
        check({tag, "_err"},      {31'd0, err},      {31'd0, m_err});
        check({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, {31'd0, m_cpu});
        check({tag, "_writes_done"}, exp_wr.size(),   32'd0);
        check({tag, "_resp_done"},   exp_resp.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
        check({tag, "_ram_cs"},   {31'd0, ram_cs},   32'd0);
        check({tag, "_ram_rw"},   {31'd0, ram_rw},   32'd1);
        check({tag, "_ram_addr"}, {23'd0, ram_addr}, 32'd0);
        check({tag, "_ram_din"},  {20'd0, ram_din},  32'd0);
        check({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, 32'd1);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        int         w0;
        int         t0;
        int         lat;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        // Two words, good checksum: 01+23+0A+BC = EA.
        fr = '{8'h4C, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEA};
        run_frame("load2", fr);
        check("load2_ack_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h4B);
        check("load2_ram0", {20'd0, mem[0]}, 32'h123);
        check("load2_ram1", {20'd0, mem[1]}, 32'hABC);
        check("load2_cpu_released", {31'd0, cpu_rstn}, 32'd1);

        // Same frame, wrong checksum: words still land in RAM.
        mem[0] = 12'h000;
        mem[1] = 12'h000;
        fr = '{8'h4C, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEB};
        run_frame("badck", fr);
        check("badck_nak_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h45);
        check("badck_err_literal", {31'd0, err}, 32'd1);
        check("badck_cpu_held", {31'd0, cpu_rstn}, 32'd0);
        check("badck_ram0", {20'd0, mem[0]}, 32'h123);
        check("badck_ram1", {20'd0, mem[1]}, 32'hABC);

        // N = 505: rejected straight after the length, nothing written.
        w0 = n_writes;
        fr = '{8'h4C, 8'h01, 8'hF9};
        run_frame("oversize", fr);
        check("oversize_nak_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h45);
        check("oversize_no_writes", n_writes - w0, 32'd0);

        // Empty frames: CK 00 accepted, CK 01 rejected, neither writes.
        w0 = n_writes;
        fr = '{8'h4C, 8'h00, 8'h00, 8'h00};
        run_frame("empty_ok", fr);
        check("empty_ok_ack_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h4B);
        fr = '{8'h4C, 8'h00, 8'h00, 8'h01};
        run_frame("empty_bad", fr);
        check("empty_bad_nak_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h45);
        check("empty_no_writes", n_writes - w0, 32'd0);

        // Truncated frame: silence after D_H must end in 'E' after ~TIMEOUT cycles.
        fr = '{8'h4C, 8'h00, 8'h01, 8'h01};
        run_frame("timeout", fr);
        lat = tx_cyc - last_rx_cyc;
        check("timeout_nak_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h45);
        check("timeout_latency_window", {31'd0, lat >= TIMEOUT && lat <= TIMEOUT + 4}, 32'd1);
        check("timeout_not_early", {31'd0, lat >= TIMEOUT}, 32'd1);

        // Noise in IDLE: no response, never busy.
        t0 = tx_log.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h41);
        repeat (20) @(posedge clk);
        #1;
        check("noise_not_busy", {31'd0, busy}, 32'd0);
        check("noise_no_resp", tx_log.size() - t0, 32'd0);

        // Start a frame (clears err), then reset mid-frame.
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h03);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        check("next_L_clears_err", {31'd0, err}, 32'd0);
        check("midframe_cpu_held", {31'd0, cpu_rstn}, 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_values("async_rst");
        #3;
        rstn = 1'b1;
        m_err = 1'b0;
        m_cpu = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Recovery frame; ignored bits set in N_H[7:1] and D_H[7:4].
        // Sum 0F+FF+1E+01+02+34 = 163 -> 63.
        fr = '{8'h4C, 8'hFE, 8'h03, 8'h0F, 8'hFF, 8'h1E, 8'h01, 8'h02, 8'h34, 8'h63};
        run_frame("load3", fr);
        check("load3_ack_literal", {24'd0, tx_log[tx_log.size()-1]}, 32'h4B);
        check("load3_ram0", {20'd0, mem[0]}, 32'hFFF);
        check("load3_ram1", {20'd0, mem[1]}, 32'hE01);
        check("load3_ram2", {20'd0, mem[2]}, 32'h234);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simplez_loader.md
Name: simplez_loader

Overview:
- Serial bootloader for the Simplez F system: the writing end of the program RAM, which the processor only reads.
- Receives a framed program image from the host through the existing uart_rx (rcv/data), assembles 12-bit words, writes them into the 512x12 RAM through a second access path, and answers through uart_tx.
- Holds the processor in reset while loading. Releases it only after a verified load.

Parameters:
- BAUD, `B115200, passed through to the top level for the uart_rx/uart_tx instances; not used internally.
- RAM_WORDS, 504, maximum loadable words; addresses 0x000-0x1F7, below the peripheral window at 0x1F8.
- TIMEOUT, 12000000, idle clock cycles allowed between received bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_rcv  in  1  one-cycle pulse from uart_rx: byte valid
- rx_data  in  8  received byte, valid with rx_rcv
- tx_ready  in  1  uart_tx idle
- tx_start  out  1  one-cycle start request to uart_tx
- tx_data  out  8  response byte
- ram_cs  out  1  RAM write-path select
- ram_rw  out  1  0 = write, 1 = read/idle
- ram_addr  out  9  RAM word address
- ram_din  out  12  RAM write data
- cpu_rstn  out  1  active-low reset to the simplez core
- busy  out  1  frame in progress
- err  out  1  last frame failed; sticky until next accepted 'L'

Behaviour:
- Reset is asynchronous. Reset values: tx_start=0, tx_data=0x00, ram_cs=0, ram_rw=1, ram_addr=0, ram_din=0, cpu_rstn=1 (core runs the ROMFILE image), busy=0, err=0, state IDLE.
- Frame format: 0x4C 'L', N_H, N_L, N x (D_H, D_L), CK.
  - N = {N_H[0], N_L}, 9 bits. N_H[7:1] are ignored.
  - Word = {D_H[3:0], D_L}. D_H[7:4] are ignored.
  - CK = 8-bit modulo sum of all D_H and D_L bytes, as received.
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CHK, RESP, DONE.
- IDLE:
  - Any byte other than 0x4C is ignored.
  - On 0x4C: enter LEN_H; set busy=1, err=0, cpu_rstn=0; clear the address counter and the checksum.
- LEN_L, N > RAM_WORDS: go to RESP with response 'E' (0x45). Nothing is written.
- LEN_L, N == 0: go directly to CHK. Expected CK = 0x00.
- DATA_H: latch the nibble and add the byte to the sum. DATA_L: add the byte to the sum, then go to WRITE.
- WRITE is exactly one cycle:
  - ram_cs=1, ram_rw=0, ram_addr=counter, ram_din=word.
  - Increment the counter.
  - Return to DATA_H, or go to CHK once the counter equals N.
- CHK, on the next byte:
  - Byte equals the sum: response 'K' (0x4B).
  - Otherwise: response 'E' and err=1.
  - Words already written remain in RAM.
- RESP:
  - Wait for tx_ready=1, then pulse tx_start for one cycle.
  - tx_data stays stable from that cycle until the state returns to IDLE.
  - Then go to DONE.
- DONE: wait for tx_ready=1 again, then go to IDLE with busy=0.
  - After 'K': cpu_rstn=1.
  - After 'E': cpu_rstn stays 0 until a later load succeeds.
- Timeout:
  - Counter is active in LEN_H, LEN_L, DATA_H, DATA_L and CHK. rx_rcv clears it.
  - Reaching TIMEOUT-1 goes to RESP with 'E' and err=1.
- rx_rcv in WRITE, RESP or DONE is ignored. This cannot occur at legal baud rates, but must not corrupt state.
- Assertion of rstn mid-frame:
  - Returns immediately to IDLE with reset values; cpu_rstn=1.
  - Partially written RAM is not restored.
- ram_cs/ram_rw are asserted only in WRITE. The top level ORs the loader path with the core path; the core is held in reset whenever the loader writes.

Decomposition:
- Shared package simplez_pkg:
  - byte codes LOAD_CMD=0x4C, ACK_OK=0x4B, ACK_ERR=0x45;
  - RAM_DATA_TOP=9'h1F8, shared with the core's peripheral decode;
  - AW=9, DW=12;
  - loader state encoding.
- One sub-module: loader_timeout. This is a clearable down-counter with enable, producing a one-cycle expiry pulse.

Test Plan:
- Load two words. Send 4C 00 02 01 23 0A BC EA:
  - RAM[0]=0x123, RAM[1]=0xABC, each written in a single WRITE cycle;
  - tx_data=0x4B; cpu_rstn rises after the ack; err=0.
- Bad checksum. Same frame with CK=0xEB:
  - 0x45 is sent; err=1; cpu_rstn stays 0; RAM[0..1] are already written.
- Oversize length. Send 4C 01 F9 (N=505):
  - immediate 0x45; no ram_cs pulse; err=1.
- Empty frame. Send 4C 00 00 00:
  - 0x4B with no RAM writes. With CK=0x01: 0x45.
- Timeout. Send 4C 00 01 01, then silence with TIMEOUT=100:
  - 0x45 after 100 idle cycles; next 'L' clears err.
- Noise and reset. Send bytes 00 FF 41 in IDLE:
  - no response and busy=0.
  - Then 4C 00 03, and assert rstn low mid-frame: all outputs at reset values asynchronously; cpu_rstn=1.
